// File: rtl/destination_writeback_unit_if.sv
// Result stream from the ALU into the writeback unit: the value, where it goes,
// and the valid/ready handshake that lets the unit apply backpressure.
interface destination_writeback_unit_if #(
    parameter int WORD_WIDTH = 32,
    parameter int DI_WIDTH   = 4
);
    logic                  result_valid;
    logic                  result_ready;
    logic [WORD_WIDTH-1:0] result;
    logic [1:0]            dt;
    logic [DI_WIDTH-1:0]   di;

    modport master (
        output result_valid,
        output result,
        output dt,
        output di,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result,
        input  dt,
        input  di,
        output result_ready
    );
endinterface

// File: rtl/destination_writeback_unit.sv
// Commits finished ALU results to the register file, predicate file or a
// one-entry output channel buffer, stalling the result stream only on a busy channel.
module destination_writeback_unit #(
    parameter int NUM_OUTPUT_CHANNELS  = 4,
    parameter int NUM_PREDICATES       = 8,
    parameter int NUM_REGISTERS        = 8,
    parameter int WORD_WIDTH           = 32,
    parameter int DI_WIDTH             = 4,
    parameter int REGISTER_INDEX_WIDTH = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1,
    parameter int PREDICATE_INDEX_WIDTH = (NUM_PREDICATES > 1) ? $clog2(NUM_PREDICATES) : 1
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    destination_writeback_unit_if.slave                    res,
    output logic                                           register_write_enable,
    output logic [REGISTER_INDEX_WIDTH-1:0]                register_write_index,
    output logic [WORD_WIDTH-1:0]                          register_write_data,
    output logic                                           predicate_write_enable,
    output logic [PREDICATE_INDEX_WIDTH-1:0]               predicate_write_index,
    output logic                                           predicate_write_value,
    output logic [NUM_OUTPUT_CHANNELS-1:0]                 output_channel_valid,
    output logic [NUM_OUTPUT_CHANNELS-1:0][WORD_WIDTH-1:0] output_channel_data,
    input  logic [NUM_OUTPUT_CHANNELS-1:0]                 output_channel_ready,
    output logic                                           quiescent,
    output logic                                           destination_error
);

    localparam int CH_IDX_W = (NUM_OUTPUT_CHANNELS > 1) ? $clog2(NUM_OUTPUT_CHANNELS) : 1;
    localparam logic [DI_WIDTH:0] NUM_CH_LIMIT   = (DI_WIDTH+1)'(NUM_OUTPUT_CHANNELS);
    localparam logic [DI_WIDTH:0] NUM_PRED_LIMIT = (DI_WIDTH+1)'(NUM_PREDICATES);

    typedef enum logic [1:0] {
        DT_NULL      = 2'd0,
        DT_REGISTER  = 2'd1,
        DT_CHANNEL   = 2'd2,
        DT_PREDICATE = 2'd3
    } destType_e;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chanState_e;

    chanState_e                                     chanState_q [NUM_OUTPUT_CHANNELS];
    chanState_e                                     chanState_d [NUM_OUTPUT_CHANNELS];
    logic [NUM_OUTPUT_CHANNELS-1:0][WORD_WIDTH-1:0] chanData_q;
    logic [NUM_OUTPUT_CHANNELS-1:0][WORD_WIDTH-1:0] chanData_d;
    logic [NUM_OUTPUT_CHANNELS-1:0]                 chanWrite;

    logic                             regEnable_q, regEnable_d;
    logic [REGISTER_INDEX_WIDTH-1:0]  regIndex_q, regIndex_d;
    logic [WORD_WIDTH-1:0]            regData_q, regData_d;
    logic                             predEnable_q, predEnable_d;
    logic [PREDICATE_INDEX_WIDTH-1:0] predIndex_q, predIndex_d;
    logic                             predValue_q, predValue_d;
    logic                             destError_q, destError_d;

    logic                isChannel;
    logic                isPredicate;
    logic                isRegister;
    logic                chanLegal;
    logic                predLegal;
    logic [CH_IDX_W-1:0] chanIdx;
    logic                chanStall;
    logic                accept;

    assign isChannel   = (res.dt == DT_CHANNEL);
    assign isPredicate = (res.dt == DT_PREDICATE);
    assign isRegister  = (res.dt == DT_REGISTER);
    assign chanLegal   = ({1'b0, res.di} < NUM_CH_LIMIT);
    assign predLegal   = ({1'b0, res.di} < NUM_PRED_LIMIT);
    assign chanIdx     = res.di[CH_IDX_W-1:0];

    // A channel write only stalls when its buffer is full and will not drain this edge.
    always_comb begin
        chanStall = 1'b0;
        if (isChannel && chanLegal) begin
            chanStall = (chanState_q[chanIdx] == CH_FULL) && !output_channel_ready[chanIdx];
        end
    end

    assign res.result_ready = reset_n & ~chanStall;
    assign accept           = res.result_valid & res.result_ready;

    always_comb begin
        for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
            chanWrite[c]   = accept && isChannel && chanLegal && (chanIdx == CH_IDX_W'(c));
            chanState_d[c] = chanState_q[c];
            chanData_d[c]  = chanData_q[c];
            case (chanState_q[c])
                CH_EMPTY: begin
                    if (chanWrite[c]) begin
                        chanState_d[c] = CH_FULL;
                        chanData_d[c]  = res.result;
                    end
                end
                CH_FULL: begin
                    // A write to a full buffer implies it is draining this same edge.
                    if (chanWrite[c]) begin
                        chanData_d[c] = res.result;
                    end else if (output_channel_ready[c]) begin
                        chanState_d[c] = CH_EMPTY;
                    end
                end
                default: begin
                    chanState_d[c] = CH_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
                chanState_q[c] <= CH_EMPTY;
            end
            chanData_q <= '0;
        end else begin
            for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
                chanState_q[c] <= chanState_d[c];
            end
            chanData_q <= chanData_d;
        end
    end

    always_comb begin
        regEnable_d  = accept && isRegister;
        regIndex_d   = regIndex_q;
        regData_d    = regData_q;
        predEnable_d = accept && isPredicate && predLegal;
        predIndex_d  = predIndex_q;
        predValue_d  = predValue_q;
        destError_d  = destError_q;
        if (regEnable_d) begin
            regIndex_d = res.di[REGISTER_INDEX_WIDTH-1:0];
            regData_d  = res.result;
        end
        if (predEnable_d) begin
            predIndex_d = res.di[PREDICATE_INDEX_WIDTH-1:0];
            predValue_d = res.result[0];
        end
        if (accept && ((isChannel && !chanLegal) || (isPredicate && !predLegal))) begin
            destError_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regEnable_q  <= 1'b0;
            regIndex_q   <= '0;
            regData_q    <= '0;
            predEnable_q <= 1'b0;
            predIndex_q  <= '0;
            predValue_q  <= 1'b0;
            destError_q  <= 1'b0;
        end else begin
            regEnable_q  <= regEnable_d;
            regIndex_q   <= regIndex_d;
            regData_q    <= regData_d;
            predEnable_q <= predEnable_d;
            predIndex_q  <= predIndex_d;
            predValue_q  <= predValue_d;
            destError_q  <= destError_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
            output_channel_valid[c] = (chanState_q[c] == CH_FULL);
        end
    end

    assign output_channel_data    = chanData_q;
    assign register_write_enable  = regEnable_q;
    assign register_write_index   = regIndex_q;
    assign register_write_data    = regData_q;
    assign predicate_write_enable = predEnable_q;
    assign predicate_write_index  = predIndex_q;
    assign predicate_write_value  = predValue_q;
    assign destination_error      = destError_q;
    assign quiescent              = ~(|output_channel_valid) & ~regEnable_q & ~predEnable_q;

endmodule

// File: tb/tb_destination_writeback_unit.sv
// Directed bench for destination_writeback_unit: register, predicate and channel
// commits, channel backpressure, illegal destinations and asynchronous reset.
module tb_destination_writeback_unit;

    localparam int NCH  = 4;
    localparam int NPR  = 8;
    localparam int WW   = 32;
    localparam int DIW  = 4;

    localparam logic [1:0] DT_NULL = 2'd0;
    localparam logic [1:0] DT_REG  = 2'd1;
    localparam logic [1:0] DT_CHAN = 2'd2;
    localparam logic [1:0] DT_PRED = 2'd3;

    logic                         clock = 1'b0;
    logic                         reset_n;
    logic                         registerWriteEnable;
    logic [2:0]                   registerWriteIndex;
    logic [WW-1:0]                registerWriteData;
    logic                         predicateWriteEnable;
    logic [2:0]                   predicateWriteIndex;
    logic                         predicateWriteValue;
    logic [NCH-1:0]               channelValid;
    logic [NCH-1:0][WW-1:0]       channelData;
    logic [NCH-1:0]               channelReady;
    logic                         quiescent;
    logic                         destinationError;

    int errors = 0;
    int checks = 0;

    destination_writeback_unit_if #(.WORD_WIDTH(WW), .DI_WIDTH(DIW)) resIf ();

    destination_writeback_unit #(
        .NUM_OUTPUT_CHANNELS(NCH),
        .NUM_PREDICATES(NPR),
        .NUM_REGISTERS(8),
        .WORD_WIDTH(WW),
        .DI_WIDTH(DIW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .res(resIf.slave),
        .register_write_enable(registerWriteEnable),
        .register_write_index(registerWriteIndex),
        .register_write_data(registerWriteData),
        .predicate_write_enable(predicateWriteEnable),
        .predicate_write_index(predicateWriteIndex),
        .predicate_write_value(predicateWriteValue),
        .output_channel_valid(channelValid),
        .output_channel_data(channelData),
        .output_channel_ready(channelReady),
        .quiescent(quiescent),
        .destination_error(destinationError)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] dt, input logic [DIW-1:0] di,
                                 input logic [WW-1:0] value);
        resIf.result_valid = valid;
        resIf.dt           = dt;
        resIf.di           = di;
        resIf.result       = value;
    endtask

    // Registered outputs are sampled 1ns after the edge; inputs change at that point too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        channelReady = '0;
        applyStimulus(1'b1, DT_REG, 4'd5, 32'hDEAD);

        repeat (3) tick();
        checkOutput("reset_ready",     64'(resIf.result_ready), 64'd0);
        checkOutput("reset_regEn",     64'(registerWriteEnable), 64'd0);
        checkOutput("reset_predEn",    64'(predicateWriteEnable), 64'd0);
        checkOutput("reset_quiescent", 64'(quiescent), 64'd1);
        checkOutput("reset_chValid",   64'(channelValid), 64'd0);
        checkOutput("reset_error",     64'(destinationError), 64'd0);

        reset_n = 1'b1;
        #1;
        checkOutput("release_ready", 64'(resIf.result_ready), 64'd1);

        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("reg_en",    64'(registerWriteEnable), 64'd1);
        checkOutput("reg_index", 64'(registerWriteIndex), 64'd5);
        checkOutput("reg_data",  64'(registerWriteData), 64'hDEAD);
        tick();
        checkOutput("reg_en_drop",   64'(registerWriteEnable), 64'd0);
        checkOutput("reg_quiescent", 64'(quiescent), 64'd1);

        applyStimulus(1'b1, DT_REG, 4'd13, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("reg_upper_di_index", 64'(registerWriteIndex), 64'd5);
        checkOutput("reg_upper_di_data",  64'(registerWriteData), 64'h1234_5678);

        applyStimulus(1'b1, DT_PRED, 4'd6, 32'h0000_0003);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("pred_en",    64'(predicateWriteEnable), 64'd1);
        checkOutput("pred_index", 64'(predicateWriteIndex), 64'd6);
        checkOutput("pred_value", 64'(predicateWriteValue), 64'd1);
        tick();
        checkOutput("pred_en_drop", 64'(predicateWriteEnable), 64'd0);

        channelReady[2] = 1'b0;
        applyStimulus(1'b1, DT_CHAN, 4'd2, 32'h11);
        #1;
        checkOutput("stall_first_ready", 64'(resIf.result_ready), 64'd1);
        tick();
        checkOutput("stall_valid2", 64'(channelValid[2]), 64'd1);
        checkOutput("stall_data2",  64'(channelData[2]), 64'h11);
        applyStimulus(1'b1, DT_CHAN, 4'd2, 32'h22);
        #1;
        checkOutput("stall_second_ready", 64'(resIf.result_ready), 64'd0);
        tick();
        checkOutput("stall_hold_data2", 64'(channelData[2]), 64'h11);
        channelReady[2] = 1'b1;
        #1;
        checkOutput("stall_release_ready", 64'(resIf.result_ready), 64'd1);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("refill_valid2", 64'(channelValid[2]), 64'd1);
        checkOutput("refill_data2",  64'(channelData[2]), 64'h22);
        tick();
        checkOutput("drain_valid2", 64'(channelValid[2]), 64'd0);

        channelReady[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, DT_CHAN, 4'd0, WW'(i));
            #1;
            checkOutput($sformatf("stream_ready_%0d", i), 64'(resIf.result_ready), 64'd1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), 64'(channelValid[0]), 64'd1);
            checkOutput($sformatf("stream_data_%0d", i),  64'(channelData[0]), 64'(i));
        end
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        tick();
        checkOutput("stream_end_valid0", 64'(channelValid[0]), 64'd0);

        channelReady[3] = 1'b0;
        applyStimulus(1'b1, DT_CHAN, 4'd3, 32'h33);
        tick();
        applyStimulus(1'b1, DT_REG, 4'd2, 32'h77);
        #1;
        checkOutput("mixed_reg_ready", 64'(resIf.result_ready), 64'd1);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("mixed_reg_data",  64'(registerWriteData), 64'h77);
        checkOutput("mixed_ch3_valid", 64'(channelValid[3]), 64'd1);
        checkOutput("mixed_busy",      64'(quiescent), 64'd0);
        channelReady[3] = 1'b1;
        tick();
        checkOutput("mixed_quiescent", 64'(quiescent), 64'd1);

        applyStimulus(1'b1, DT_CHAN, 4'(NCH), 32'hBAD);
        #1;
        checkOutput("illegal_ch_ready", 64'(resIf.result_ready), 64'd1);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("illegal_ch_valid", 64'(channelValid), 64'd0);
        checkOutput("illegal_ch_error", 64'(destinationError), 64'd1);
        repeat (10) tick();
        checkOutput("illegal_error_sticky", 64'(destinationError), 64'd1);

        applyStimulus(1'b1, DT_NULL, 4'd1, 32'hFFFF);
        #1;
        checkOutput("null_ready", 64'(resIf.result_ready), 64'd1);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("null_quiescent", 64'(quiescent), 64'd1);
        checkOutput("null_regdata",   64'(registerWriteData), 64'h77);

        channelReady[1] = 1'b0;
        applyStimulus(1'b1, DT_CHAN, 4'd1, 32'h55);
        tick();
        checkOutput("midreset_valid1_before", 64'(channelValid[1]), 64'd1);
        applyStimulus(1'b1, DT_CHAN, 4'd1, 32'h66);
        #1;
        checkOutput("midreset_stalled", 64'(resIf.result_ready), 64'd0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_valid1", 64'(channelValid[1]), 64'd0);
        checkOutput("midreset_data1",  64'(channelData[1]), 64'd0);
        checkOutput("midreset_error",  64'(destinationError), 64'd0);
        checkOutput("midreset_ready",  64'(resIf.result_ready), 64'd0);
        checkOutput("midreset_quiet",  64'(quiescent), 64'd1);
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        applyStimulus(1'b1, DT_PRED, 4'(NPR), 32'h1);
        tick();
        applyStimulus(1'b0, DT_NULL, 4'd0, 32'h0);
        checkOutput("illegal_pred_en",    64'(predicateWriteEnable), 64'd0);
        checkOutput("illegal_pred_error", 64'(destinationError), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/destination_writeback_unit.md
# destination_writeback_unit

Write-side counterpart of operand sourcing in the PE datapath. Takes a completed ALU result with its destination type/index, commits it to the register file, the predicate file, or an output channel. Output channels get a one-entry holding buffer each, so a result bound for a busy channel stalls the upstream result stream without losing data.

## Interface

- NUM_OUTPUT_CHANNELS, TIA_NUM_OUTPUT_CHANNELS: number of output channels.
- NUM_PREDICATES, TIA_NUM_PREDICATES: predicate file size.
- WORD_WIDTH, TIA_WORD_WIDTH: result/data width.
- DI_WIDTH, TIA_DI_WIDTH: destination index width; must cover max(register count, NUM_OUTPUT_CHANNELS, NUM_PREDICATES).
- clock  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- result_valid  in  1  result offered this cycle.
- result_ready  out  1  unit accepts the offered result; transfer = valid & ready at rising edge.
- result  in  WORD_WIDTH  value to write.
- dt  in  2  destination type: 0 NULL, 1 REGISTER, 2 CHANNEL, 3 PREDICATE.
- di  in  DI_WIDTH  destination index.
- register_write_enable  out  1  one-cycle register write strobe.
- register_write_index  out  TIA_REGISTER_INDEX_WIDTH  register index (low bits of di).
- register_write_data  out  WORD_WIDTH  register write value.
- predicate_write_enable  out  1  one-cycle predicate write strobe.
- predicate_write_index  out  clog2(NUM_PREDICATES)  predicate index.
- predicate_write_value  out  1  result[0].
- output_channel_valid  out  [NUM_OUTPUT_CHANNELS]  per-channel buffer occupied.
- output_channel_data  out  WORD_WIDTH x NUM_OUTPUT_CHANNELS  per-channel buffered value.
- output_channel_ready  in  [NUM_OUTPUT_CHANNELS]  downstream accepts channel word.
- quiescent  out  1  no buffered channel words and no pending strobe.
- destination_error  out  1  sticky: an illegal destination was accepted.

## Operation

- Per-channel state: EMPTY, FULL. EMPTY→FULL on accepted CHANNEL result to that channel. FULL→EMPTY on valid & ready with no new write to that channel. FULL stays FULL when drained and refilled in the same cycle; buffer takes new data.
- result_ready = reset_n & ~(dt==CHANNEL & di legal & buffer[di] FULL & ~output_channel_ready[di]). All other dt values are always ready.
- REGISTER: accepted result registered into write_index/data; enable high exactly next cycle.
- PREDICATE: same, with predicate_write_value = result[0].
- NULL: accepted, discarded, no side effect, no error.
- Illegal: CHANNEL with di ≥ NUM_OUTPUT_CHANNELS, or PREDICATE with di ≥ NUM_PREDICATES. Accept (ready=1), discard, set destination_error. Only reset clears it.
- Register index is never illegal; upper di bits are ignored.
- quiescent = all channel buffers EMPTY & ~register_write_enable & ~predicate_write_enable.
- Reset (async assert, any cycle, including mid-stall): all buffers EMPTY, all channel valid 0, data 0, all strobes/indices/data 0, destination_error 0, result_ready 0 while asserted, quiescent 1.

## Timing

- Register/predicate latency: accepted at edge N, strobe high for the cycle after N, low after N+1 unless another write is accepted.
- Channel latency: accepted at edge N, valid from the cycle after N until the edge where ready=1.
- Channel throughput is 1 word/cycle per channel while downstream ready stays high.
- Back-to-back writes to different destinations never stall each other.
- Data and valid are registered; no combinational path from result to channel outputs.
- Only combinational paths: output_channel_ready→result_ready, and dt/di→result_ready.

## Test plan

- Reset: hold reset_n=0 with result_valid=1, dt=REGISTER → result_ready=0, all strobes 0, quiescent=1. Release → result_ready=1.
- Register write: result=0xDEAD, dt=1, di=5 accepted at edge N → next cycle enable=1, index=5, data=0xDEAD. Then enable=0 with quiescent=1.
- Channel stall: ready[2]=0, two CHANNEL writes to di=2 (0x11, 0x22) → first accepted, valid[2]=1 with 0x11. Second sees result_ready=0. Raise ready[2] → 0x11 drains, 0x22 accepted the same edge, data=0x22.
- Streaming: ready[0]=1, four consecutive CHANNEL writes to ch0 (1,2,3,4) → result_ready stays 1, data sequence 1,2,3,4 on consecutive cycles, then valid[0]=0.
- Illegal destinations: dt=CHANNEL, di=NUM_OUTPUT_CHANNELS → accepted, no valid asserted, destination_error=1, still set after 10 idle cycles. dt=NULL → no effect.
- Mid-stall reset: channel 1 FULL, ready=0, pulse reset_n low asynchronously → valid[1]=0 immediately, destination_error=0.
